usart_frame_recv: RTL and testbench

- UART receive-side command deframer that sits directly upstream of the 5-byte UART transmit/echo block.
- Deserialises 8N1 bytes from uart_rxd and assembles 5-byte command frames.
- Presents Adress / Mod_SEL / D, then pulses trig so the transmit block latches those fields and sends them back.
- Also detects inter-byte timeouts and bad stop bits, and discards partial frames.

---
 rtl/usart_frame_recv.sv | 155 +++++++++++++++
 tb/tb_usart_frame_recv.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/usart_frame_recv.sv
// 8N1 UART receiver that assembles 5-byte command frames into Adress/Mod_SEL/D
// and pulses trig; drops partial frames on stop-bit error or inter-byte timeout.
module usart_frame_recv #(
    parameter logic [15:0] BPS_CNT     = 16'd434,
    parameter logic [15:0] TIMEOUT_CNT = 16'd8680
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        uart_rxd,
    output logic [23:0] D,
    output logic [1:0]  Adress,
    output logic [5:0]  Mod_SEL,
    output logic        trig,
    output logic        frame_err,
    output logic        busy
);

    localparam logic [15:0] HALF_END = BPS_CNT / 16'd2 - 16'd1;
    localparam logic [15:0] BIT_END  = BPS_CNT - 16'd1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_state_t;

    logic        rxd_meta_reg;
    logic        rxd_s;
    logic        rxd_d_reg;
    logic        fall_edge;

    bit_state_t  state_reg;
    logic [15:0] bit_cnt_reg;
    logic [2:0]  bit_idx_reg;
    logic [7:0]  shift_reg;
    logic        byte_valid_reg;
    logic        stop_err_reg;

    logic [2:0]  idx_reg;
    logic [7:0]  shadow_reg [0:3];
    logic [15:0] to_cnt_reg;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rxd_meta_reg <= 1'b1;
            rxd_s        <= 1'b1;
            rxd_d_reg    <= 1'b1;
        end else begin
            rxd_meta_reg <= uart_rxd;
            rxd_s        <= rxd_meta_reg;
            rxd_d_reg    <= rxd_s;
        end
    end

    assign fall_edge = rxd_d_reg & ~rxd_s;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= 16'd0;
            bit_idx_reg    <= 3'd0;
            shift_reg      <= 8'd0;
            byte_valid_reg <= 1'b0;
            stop_err_reg   <= 1'b0;
        end else begin
            byte_valid_reg <= 1'b0;
            stop_err_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (fall_edge) begin
                        state_reg   <= START;
                        bit_cnt_reg <= 16'd0;
                    end
                end
                START: begin
                    if (bit_cnt_reg == HALF_END) begin
                        bit_cnt_reg <= 16'd0;
                        bit_idx_reg <= 3'd0;
                        // A line already back high at mid-start is a glitch, not a byte.
                        state_reg   <= rxd_s ? IDLE : DATA;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_cnt_reg == BIT_END) begin
                        bit_cnt_reg <= 16'd0;
                        shift_reg   <= {rxd_s, shift_reg[7:1]};
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_cnt_reg == BIT_END) begin
                        // Leave at mid-stop so a back-to-back start edge is seen.
                        bit_cnt_reg    <= 16'd0;
                        state_reg      <= IDLE;
                        byte_valid_reg <= rxd_s;
                        stop_err_reg   <= ~rxd_s;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 16'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            idx_reg    <= 3'd0;
            to_cnt_reg <= 16'd0;
            D          <= 24'd0;
            Adress     <= 2'd0;
            Mod_SEL    <= 6'd0;
            trig       <= 1'b0;
            frame_err  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow_reg[i] <= 8'd0;
            end
        end else begin
            trig      <= 1'b0;
            frame_err <= 1'b0;
            if (byte_valid_reg) begin
                to_cnt_reg <= 16'd0;
                if (idx_reg == 3'd4) begin
                    Adress  <= shadow_reg[0][1:0];
                    Mod_SEL <= shadow_reg[1][5:0];
                    D       <= {shadow_reg[2], shadow_reg[3], shift_reg};
                    trig    <= 1'b1;
                    idx_reg <= 3'd0;
                end else begin
                    shadow_reg[idx_reg[1:0]] <= shift_reg;
                    idx_reg                  <= idx_reg + 3'd1;
                end
            end else if (stop_err_reg) begin
                idx_reg    <= 3'd0;
                to_cnt_reg <= 16'd0;
                frame_err  <= 1'b1;
            end else if (idx_reg == 3'd0) begin
                to_cnt_reg <= 16'd0;
            end else if (to_cnt_reg == TIMEOUT_CNT) begin
                idx_reg    <= 3'd0;
                to_cnt_reg <= 16'd0;
                frame_err  <= 1'b1;
            end else if (state_reg == IDLE) begin
                to_cnt_reg <= to_cnt_reg + 16'd1;
            end
        end
    end

    assign busy = (idx_reg != 3'd0) || (state_reg != IDLE);

endmodule

// File: tb/tb_usart_frame_recv.sv
// Directed bench for usart_frame_recv: good frames, timeout, stop error,
// idle glitch and mid-frame reset, with hand-computed expected fields.
module tb_usart_frame_recv;

    logic        sys_clk;
    logic        sys_rst;
    logic        uart_rxd;
    logic [23:0] D;
    logic [1:0]  Adress;
    logic [5:0]  Mod_SEL;
    logic        trig;
    logic        frame_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int unsigned cyc = 0;
    int unsigned start_cyc = 0;
    int unsigned trig_cyc = 0;
    int unsigned err_cyc = 0;
    int trig_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int trig0;
    int err0;
    int unsigned byte3_end;

    usart_frame_recv #(
        .BPS_CNT    (16'd16),
        .TIMEOUT_CNT(16'd400)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .uart_rxd (uart_rxd),
        .D        (D),
        .Adress   (Adress),
        .Mod_SEL  (Mod_SEL),
        .trig     (trig),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc++;

    always @(negedge sys_clk) begin
        if (trig) begin
            trig_cnt++;
            trig_cyc = cyc;
        end
        if (frame_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (trig && frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic bit_time();
        repeat (16) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(posedge sys_clk);
        #1;
        uart_rxd  = 1'b0;
        start_cyc = cyc;
        for (int i = 0; i < 8; i++) begin
            bit_time();
            uart_rxd = b[i];
        end
        bit_time();
        uart_rxd = stop_bit;
        bit_time();
        uart_rxd = 1'b1;
        $display("tx byte %02h stop=%0b", b, stop_bit);
    endtask

    task automatic send_frame(input logic [39:0] f);
        for (int i = 4; i >= 0; i--) begin
            send_byte(f[i*8 +: 8], 1'b1);
        end
        repeat (20) @(posedge sys_clk);
        #1;
        $display("frame %010h done: Adress=%0h Mod_SEL=%0h D=%06h", f, Adress, Mod_SEL, D);
    endtask

    task automatic check_fields(input string tag, input logic [1:0] a, input logic [5:0] m,
                                input logic [23:0] d);
        check({tag, "_adress"}, {30'd0, Adress}, {30'd0, a});
        check({tag, "_modsel"}, {26'd0, Mod_SEL}, {26'd0, m});
        check({tag, "_d"}, {8'd0, D}, {8'd0, d});
    endtask

    initial begin
        uart_rxd = 1'b1;
        sys_rst  = 1'b1;
        repeat (5) @(posedge sys_clk);
        #1;
        check_fields("reset", 2'd0, 6'd0, 24'd0);
        check("reset_trig", {31'd0, trig}, 32'd0);
        check("reset_err", {31'd0, frame_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        sys_rst = 1'b0;
        repeat (5) @(posedge sys_clk);
        #1;

        // Frame 1 plus trig latency from byte5's start edge
        trig0 = trig_cnt; err0 = err_cnt;
        send_frame(40'h02_15_AB_CD_EF);
        check("f1_trigs", trig_cnt - trig0, 32'd1);
        check("f1_errs", err_cnt - err0, 32'd0);
        check_fields("f1", 2'b10, 6'h15, 24'hABCDEF);
        check("f1_latency_ok", {31'd0, (trig_cyc - start_cyc >= 154) && (trig_cyc - start_cyc <= 157)}, 32'd1);
        check("f1_busy", {31'd0, busy}, 32'd0);

        // Frame 2: ignored upper bits of byte1/byte2
        trig0 = trig_cnt;
        send_frame(40'hFF_FF_12_34_56);
        check("f2_trigs", trig_cnt - trig0, 32'd1);
        check_fields("f2", 2'b11, 6'h3F, 24'h123456);

        // Partial frame then timeout
        trig0 = trig_cnt; err0 = err_cnt;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        byte3_end = cyc;
        repeat (500) @(posedge sys_clk);
        #1;
        check("to_errs", err_cnt - err0, 32'd1);
        check("to_delay_ok", {31'd0, (err_cyc - byte3_end >= 390) && (err_cyc - byte3_end <= 410)}, 32'd1);
        check("to_trigs", trig_cnt - trig0, 32'd0);
        check_fields("to_hold", 2'b11, 6'h3F, 24'h123456);
        check("to_busy", {31'd0, busy}, 32'd0);
        send_frame(40'h01_02_00_00_07);
        check("to_f_trigs", trig_cnt - trig0, 32'd1);
        check_fields("to_f", 2'd1, 6'd2, 24'h000007);

        // Stop-bit error on byte2
        trig0 = trig_cnt; err0 = err_cnt;
        send_byte(8'h03, 1'b1);
        send_byte(8'h2A, 1'b0);
        repeat (50) @(posedge sys_clk);
        #1;
        check("se_errs", err_cnt - err0, 32'd1);
        check("se_trigs", trig_cnt - trig0, 32'd0);
        check_fields("se_hold", 2'd1, 6'd2, 24'h000007);
        send_frame(40'h00_3C_A5_5A_C3);
        check("se_f_trigs", trig_cnt - trig0, 32'd1);
        check_fields("se_f", 2'd0, 6'h3C, 24'hA55AC3);

        // Short low glitch while idle
        trig0 = trig_cnt; err0 = err_cnt;
        @(posedge sys_clk);
        #1;
        uart_rxd = 1'b0;
        repeat (4) @(posedge sys_clk);
        #1;
        uart_rxd = 1'b1;
        $display("glitch 4 clocks");
        repeat (40) @(posedge sys_clk);
        #1;
        check("gl_errs", err_cnt - err0, 32'd0);
        check("gl_trigs", trig_cnt - trig0, 32'd0);
        check("gl_busy", {31'd0, busy}, 32'd0);
        check_fields("gl_hold", 2'd0, 6'h3C, 24'hA55AC3);

        // Reset after byte4, then a full frame
        trig0 = trig_cnt;
        send_byte(8'h01, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (4) @(posedge sys_clk);
        #1;
        check("rs_busy_pre", {31'd0, busy}, 32'd1);
        sys_rst = 1'b1;
        $display("reset asserted mid-frame");
        repeat (3) @(posedge sys_clk);
        #1;
        check_fields("rs_in", 2'd0, 6'd0, 24'd0);
        check("rs_in_busy", {31'd0, busy}, 32'd0);
        sys_rst = 1'b0;
        repeat (5) @(posedge sys_clk);
        #1;
        send_frame(40'h02_07_01_02_03);
        check("rs_trigs", trig_cnt - trig0, 32'd1);
        check_fields("rs_f", 2'b10, 6'h07, 24'h010203);

        check("no_trig_err_overlap", both_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
